// File: rtl/hilo_muldiv_unit_pkg.sv
// ============================================================================
// Module : hilo_muldiv_unit_pkg
// Brief  : Opcodes, FSM states and HI/LO enable positions for the HILO unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hilo_muldiv_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Matches the decoder's HILO_enD ordering.
  localparam int HILO_HI = 1;
  localparam int HILO_LO = 0;

  typedef enum logic [1:0] {
    HL_IDLE = 2'd0,
    HL_DIV  = 2'd1,
    HL_DONE = 2'd2
  } hl_state_t;

  function automatic logic [31:0] f_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] f_neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_muldiv_unit_if.sv
// ============================================================================
// Module : hilo_muldiv_unit_if
// Brief  : Execute-stage bus between the pipeline and the HI/LO mul/div unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hilo_muldiv_unit_if;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic [1:0]  hilo_weE;
  logic [31:0] hilo_wdataE;
  logic        hilo_rselE;
  logic        cancelE;
  logic [31:0] hilo_rdataE;
  logic        stallE;
  logic        busy;

  modport slave (
    input  startE, opE, srcaE, srcbE, hilo_weE, hilo_wdataE, hilo_rselE, cancelE,
    output hilo_rdataE, stallE, busy
  );

  modport master (
    output startE, opE, srcaE, srcbE, hilo_weE, hilo_wdataE, hilo_rselE, cancelE,
    input  hilo_rdataE, stallE, busy
  );
endinterface

`default_nettype wire

// File: rtl/hilo_muldiv_unit_div_radix2.sv
// ============================================================================
// Module : div_radix2
// Brief  : Unsigned restoring divider, one quotient bit per cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_radix2 #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_cancel,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  localparam int             CW     = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0]  C_LAST = CW'(DIV_CYCLES - 1);

  logic [31:0]   r_rem;
  logic [31:0]   r_quo;
  logic [31:0]   r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_run;

  logic [32:0]   w_shift;
  logic [32:0]   w_diff;
  logic          w_fit;
  logic [31:0]   w_rem_nxt;
  logic [31:0]   w_quo_nxt;

  // r_quo starts as the dividend and is shifted out MSB-first as quotient bits enter.
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_fit     = ~w_diff[32];
  assign w_rem_nxt = w_fit ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_fit};

  assign o_done      = r_run && (r_cnt == C_LAST);
  assign o_quotient  = w_quo_nxt;
  assign o_remainder = w_rem_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_cancel) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      if (o_done) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
// ============================================================================
// Module : hilo_muldiv_unit
// Brief  : HI/LO registers with single-cycle multiply and iterative divide.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  hilo_muldiv_unit_if.slave       bus
);

  hl_state_t   r_state;
  hl_state_t   w_state_nxt;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_div0;

  logic        w_idle;
  logic        w_in_div;
  logic        w_go;
  logic        w_mul_go;
  logic        w_div_go;
  logic        w_mt_go;
  logic        w_is_signed;
  logic        w_div_cancel;
  logic        w_div_done;
  logic        w_div_commit;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [31:0] w_quo_raw;
  logic [31:0] w_rem_raw;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_idle       = (r_state == HL_IDLE);
  assign w_in_div     = (r_state == HL_DIV);
  assign w_go         = bus.startE && !bus.cancelE && w_idle;
  assign w_mul_go     = w_go && !bus.opE[1];
  assign w_div_go     = w_go && bus.opE[1];
  assign w_mt_go      = !bus.startE && !bus.cancelE && w_idle;
  assign w_is_signed  = !bus.opE[0];
  assign w_div_cancel = w_in_div && bus.cancelE;
  assign w_div_commit = w_in_div && !bus.cancelE && w_div_done;

  // Extending to 64 bits first makes the low 64 bits of the product exact for both signednesses.
  assign w_ext_a = {{32{w_is_signed & bus.srcaE[31]}}, bus.srcaE};
  assign w_ext_b = {{32{w_is_signed & bus.srcbE[31]}}, bus.srcbE};
  assign w_prod  = w_ext_a * w_ext_b;

  div_radix2 #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_go),
    .i_cancel    (w_div_cancel),
    .i_dividend  (f_mag(bus.srcaE, w_is_signed)),
    .i_divisor   (f_mag(bus.srcbE, w_is_signed)),
    .o_done      (w_div_done),
    .o_quotient  (w_quo_raw),
    .o_remainder (w_rem_raw)
  );

  // A zero divisor leaves |a| in the remainder, so the sign fixup restores the raw dividend.
  assign w_quo_fix = r_div0 ? 32'hFFFF_FFFF : f_neg_if(w_quo_raw, r_qneg);
  assign w_rem_fix = f_neg_if(w_rem_raw, r_rneg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HL_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HL_IDLE: if (w_div_go)          w_state_nxt = HL_DIV;
      HL_DIV: begin
        if (bus.cancelE)              w_state_nxt = HL_IDLE;
        else if (w_div_done)          w_state_nxt = HL_DONE;
      end
      HL_DONE:                        w_state_nxt = HL_IDLE;
      default:                        w_state_nxt = HL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_div0 <= 1'b0;
    end else if (w_div_go) begin
      r_qneg <= w_is_signed && (bus.srcaE[31] ^ bus.srcbE[31]);
      r_rneg <= w_is_signed && bus.srcaE[31];
      r_div0 <= (bus.srcbE == 32'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_mul_go) begin
      r_hi <= w_prod[63:32];
      r_lo <= w_prod[31:0];
    end else if (w_div_commit) begin
      r_hi <= w_rem_fix;
      r_lo <= w_quo_fix;
    end else if (w_mt_go) begin
      if (bus.hilo_weE[HILO_HI]) r_hi <= bus.hilo_wdataE;
      if (bus.hilo_weE[HILO_LO]) r_lo <= bus.hilo_wdataE;
    end
  end

  assign bus.stallE      = w_div_go || w_in_div;
  assign bus.busy        = !w_idle;
  assign bus.hilo_rdataE = bus.hilo_rselE ? r_hi : r_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
// ============================================================================
// Module : tb_hilo_muldiv_unit
// Brief  : Directed and randomized checks of hilo_muldiv_unit against a model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_muldiv_unit_if bus ();

  hilo_muldiv_unit #(.DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.hilo_rselE = 1'b1;
    #1 hi = bus.hilo_rdataE;
    bus.hilo_rselE = 1'b0;
    #1 lo = bus.hilo_rdataE;
  endtask

  task automatic chk_hilo(input string tag);
    logic [31:0] hi, lo;
    read_hilo(hi, lo);
    chk({tag, ".HI"}, hi, m_hi);
    chk({tag, ".LO"}, lo, m_lo);
  endtask

  // Reference model: plain arithmetic on the architectural rules.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    longint sa, sb;
    if (op == MD_MULTU) return {32'd0, a} * {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (op == MD_DIVU) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb);
    end
  endtask

  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic [63:0] p;
    @(negedge clk);
    bus.startE = 1'b1; bus.opE = op; bus.srcaE = a; bus.srcbE = b;
    #1 chk("mul.stall", 32'(bus.stallE), 32'd0);
    @(negedge clk);
    bus.startE = 1'b0;
    p = ref_mul(a, b, op);
    m_hi = p[63:32]; m_lo = p[31:0];
    chk_hilo("mul");
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    int n;
    @(negedge clk);
    bus.startE = 1'b1; bus.opE = op; bus.srcaE = a; bus.srcbE = b;
    #1;
    n = 0;
    while (bus.stallE && n < 100) begin
      n++;
      @(negedge clk);
      bus.startE = 1'b0;
      #1;
    end
    bus.startE = 1'b0;
    chk("div.stall_cycles", 32'(n), 32'd33);
    chk("div.busy_done", 32'(bus.busy), 32'd1);
    ref_div(a, b, op, m_lo, m_hi);
    chk_hilo("div");
    @(negedge clk);
    #1 chk("div.busy_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_mt(input logic [1:0] we, input logic [31:0] d);
    @(negedge clk);
    bus.hilo_weE = we; bus.hilo_wdataE = d;
    @(negedge clk);
    bus.hilo_weE = 2'b00;
    if (we[HILO_HI]) m_hi = d;
    if (we[HILO_LO]) m_lo = d;
  endtask

  initial begin
    logic [31:0] a, b, hi, lo;
    logic [1:0]  op;
    n_vec = 0; n_err = 0;
    m_hi = '0; m_lo = '0;
    rst = 1'b1;
    bus.startE = 1'b0; bus.opE = 2'b00; bus.srcaE = '0; bus.srcbE = '0;
    bus.hilo_weE = 2'b00; bus.hilo_wdataE = '0; bus.hilo_rselE = 1'b0; bus.cancelE = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.stall", 32'(bus.stallE), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk_hilo("rst");
    rst = 1'b0;

    do_mult(32'hFFFF_FFFE, 32'd3, MD_MULT);
    chk("mult.HI_const", m_hi, 32'hFFFF_FFFF);
    do_mult(32'hFFFF_FFFE, 32'd3, MD_MULTU);
    chk("multu.HI_const", m_hi, 32'h0000_0002);

    do_div(32'hFFFF_FFF9, 32'd2, MD_DIV);
    chk("div_m7.LO_const", m_lo, 32'hFFFF_FFFD);
    do_div(32'd100, 32'd7, MD_DIVU);
    do_div(32'h1234, 32'd0, MD_DIVU);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, MD_DIV);
    do_div(32'hFFFF_FF00, 32'd0, MD_DIV);

    // Cancel in the tenth DIV cycle.
    do_mt(2'b10, 32'h0000_AAAA);
    do_mt(2'b01, 32'h0000_5555);
    @(negedge clk);
    bus.startE = 1'b1; bus.opE = MD_DIV; bus.srcaE = 32'd1000; bus.srcbE = 32'd3;
    @(negedge clk);
    bus.startE = 1'b0;
    repeat (9) @(negedge clk);
    bus.cancelE = 1'b1;
    #1 chk("cancel.stall_during", 32'(bus.stallE), 32'd1);
    @(negedge clk);
    bus.cancelE = 1'b0;
    #1 chk("cancel.stall_after", 32'(bus.stallE), 32'd0);
    chk("cancel.busy_after", 32'(bus.busy), 32'd0);
    chk_hilo("cancel");

    do_mt(2'b01, 32'h0000_DEAD);
    chk_hilo("mtlo");
    do_mt(2'b11, 32'h0BAD_F00D);
    chk_hilo("mt_both");

    // startE wins over a simultaneous MTLO.
    @(negedge clk);
    bus.startE = 1'b1; bus.opE = MD_MULT; bus.srcaE = 32'd3; bus.srcbE = 32'd4;
    bus.hilo_weE = 2'b01; bus.hilo_wdataE = 32'h0000_BEEF;
    @(negedge clk);
    bus.startE = 1'b0; bus.hilo_weE = 2'b00;
    m_hi = 32'd0; m_lo = 32'd12;
    chk_hilo("start_wins");

    // Async reset in the fifth DIV cycle.
    @(negedge clk);
    bus.startE = 1'b1; bus.opE = MD_DIVU; bus.srcaE = 32'd77; bus.srcbE = 32'd5;
    @(negedge clk);
    bus.startE = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rstmid.busy", 32'(bus.busy), 32'd0);
    chk("rstmid.stall", 32'(bus.stallE), 32'd0);
    m_hi = '0; m_lo = '0;
    chk_hilo("rstmid");
    @(negedge clk);
    rst = 1'b0;
    do_div(32'd9, 32'd3, MD_DIVU);

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 5)) - 32'd2;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if (op[1]) do_div(a, b, op);
      else       do_mult(a, b, op);
      if ($urandom_range(0, 2) == 0) begin
        do_mt(2'($urandom_range(1, 3)), $urandom);
        read_hilo(hi, lo);
        chk("rnd_mt.HI", hi, m_hi);
        chk("rnd_mt.LO", lo, m_lo);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
